// File: rtl/fast_corner_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fast_corner_packer_if
//  Description : Bundles the two streams around the corner packer.
//                Pixel side (from the FAST detector):
//                  ce, xy_coord_vld, iscorner, x_coord[9:0], y_coord[9:0],
//                  score[12:0]
//                Record side (to DMA/host), valid/ready:
//                  m_data[31:0], m_valid, m_last, m_ready
//                modport master : the packer (consumes pixels, sources records)
//                modport slave  : the environment (sources pixels, sinks records)
//  Revision    : 1.0  initial release
// ============================================================================
interface fast_corner_packer_if;
    // pixel stream
    logic        ce;
    logic        xy_coord_vld;
    logic        iscorner;
    logic [9:0]  x_coord;
    logic [9:0]  y_coord;
    logic [12:0] score;
    // record stream
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;

    modport master (
        input  ce, xy_coord_vld, iscorner, x_coord, y_coord, score,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        output ce, xy_coord_vld, iscorner, x_coord, y_coord, score,
        input  m_data, m_valid, m_last,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/fast_corner_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fast_corner_packer
//  Description : Receiving end of the FAST detector stream. Keeps only corner
//                pixels, packs each into a 32-bit record, buffers the records
//                in a first-word-fall-through FIFO and drains them over a
//                valid/ready stream. One end-of-frame (EOF) summary word is
//                appended per frame.
//
//                Corner word : {1'b0, sat11(score), y[9:0], x[9:0]}
//                EOF word    : {1'b1, ovf, 14'd0, ncorner[15:0]}
//
//  Ports       : clk        clock
//                rst        asynchronous reset, active low
//                bus        fast_corner_packer_if.master (pixel in / record out)
//                min_score  [12:0] minimum accepted score (filter build only)
//                frame_cnt  [15:0] EOF words written so far, wraps
//
//  Build macro : FAST_PACK_SCORE_FILTER_EN -- when defined, adds the
//                min_score port; corners with score < min_score are ignored
//                (not counted, no overflow flag).
//
//  Revision    : 1.0  initial release
// ============================================================================
module fast_corner_packer #(
    parameter int COL_NUM     = 640,
    parameter int ROW_NUM     = 480,
    parameter int FIFO_DEPTH  = 64,
    parameter int MAX_CORNERS = 4095
) (
    input  wire logic               clk,
    input  wire logic               rst,
    fast_corner_packer_if.master    bus,
`ifdef FAST_PACK_SCORE_FILTER_EN
    input  wire logic [12:0]        min_score,
`endif
    output logic [15:0]             frame_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int             c_AW       = $clog2(FIFO_DEPTH);
    localparam int             c_PW       = c_AW + 1;
    localparam logic [c_PW-1:0] c_DEPTH    = c_PW'(FIFO_DEPTH);
    // Highest fill at which a corner may still be written: the last slot is
    // kept free so the EOF word of the current frame always has a home.
    localparam logic [c_PW-1:0] c_DEPTH_M2 = c_PW'(FIFO_DEPTH - 2);
    localparam logic [15:0]     c_MAX      = 16'(MAX_CORNERS);
    localparam logic [9:0]      c_X_LAST   = 10'(COL_NUM - 1);
    localparam logic [9:0]      c_Y_LAST   = 10'(ROW_NUM - 1);
    localparam logic [12:0]     c_SAT_MAX  = 13'd2047;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_EOF_PEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Input qualification (combinational)
    // ------------------------------------------------------------------------
    logic        w_score_ok;
    logic        w_corner_evt;
    logic        w_frame_end;
    logic [10:0] w_score_sat;
    logic [31:0] w_corner_word;

`ifdef FAST_PACK_SCORE_FILTER_EN
    assign w_score_ok = (bus.score >= min_score);
`else
    assign w_score_ok = 1'b1;
`endif

    assign w_corner_evt  = bus.ce & bus.xy_coord_vld & bus.iscorner & w_score_ok;
    assign w_frame_end   = bus.ce & bus.xy_coord_vld &
                           (bus.x_coord == c_X_LAST) & (bus.y_coord == c_Y_LAST);
    assign w_score_sat   = (bus.score > c_SAT_MAX) ? 11'h7FF : bus.score[10:0];
    assign w_corner_word = {1'b0, w_score_sat, bus.y_coord, bus.x_coord};

    // ------------------------------------------------------------------------
    // Input register stage
    //   r_cap_*   : captured corner, written to the FIFO on the next edge.
    //   r_fe_d    : frame-end seen, delayed one more stage into r_eof_req so
    //               a corner on the last pixel lands in the FIFO one edge
    //               before its frame's EOF word.
    // ------------------------------------------------------------------------
    logic        r_cap_vld;
    logic [31:0] r_cap_word;
    logic        r_fe_d;
    logic        r_eof_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cap_vld  <= 1'b0;
            r_cap_word <= '0;
            r_fe_d     <= 1'b0;
            r_eof_req  <= 1'b0;
        end else begin
            r_cap_vld  <= w_corner_evt;
            r_cap_word <= w_corner_word;
            r_fe_d     <= w_frame_end;
            r_eof_req  <= r_fe_d;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    // ------------------------------------------------------------------------
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] w_fill;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic [31:0]     w_push_data;
    logic [31:0]     w_head;

    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_fill == '0);
    assign w_pop   = ~w_empty & bus.m_ready;
    assign w_head  = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    // Head of the FIFO drives the stream directly; it only changes on a pop,
    // so data/last hold steady while the sink stalls.
    assign bus.m_valid = ~w_empty;
    assign bus.m_data  = w_empty ? 32'd0 : w_head;
    assign bus.m_last  = ~w_empty & w_head[31];

    // ------------------------------------------------------------------------
    // Per-frame bookkeeping
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ncorner;
    logic        r_ovf;
    logic        r_ovf_next;     // drops that belong to the frame after the EOF
    logic [15:0] r_frame_cnt;
    logic        w_eof_wr;
    logic        w_accept;
    logic        w_drop_cur;
    logic        w_drop_next;
    logic [31:0] w_eof_word;

    assign w_eof_word = {1'b1, r_ovf, 14'd0, r_ncorner};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, write-port arbitration and corner accept/drop decision.
    // While an EOF is pending or being written, any captured corner already
    // belongs to the next frame; it is dropped and charged to that frame.
    always_comb begin
        w_state_nxt = r_state;
        w_eof_wr    = 1'b0;
        w_accept    = 1'b0;
        w_drop_cur  = 1'b0;
        w_drop_next = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (r_eof_req) begin
                    if (w_fill < c_DEPTH) begin
                        w_eof_wr = 1'b1;
                    end else begin
                        w_state_nxt = ST_EOF_PEND;
                    end
                end
            end
            ST_EOF_PEND: begin
                if (w_fill < c_DEPTH) begin
                    w_eof_wr    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (r_cap_vld) begin
            if ((r_state == ST_EOF_PEND) || w_eof_wr) begin
                w_drop_next = 1'b1;
            end else if ((w_fill <= c_DEPTH_M2) && (r_ncorner < c_MAX)) begin
                w_accept = 1'b1;
            end else begin
                w_drop_cur = 1'b1;
            end
        end
    end

    assign w_push      = w_eof_wr | w_accept;
    assign w_push_data = w_eof_wr ? w_eof_word : r_cap_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ncorner   <= '0;
            r_ovf       <= 1'b0;
            r_ovf_next  <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_eof_wr) begin
            // Summary is out: open the next frame, inheriting its early drops.
            r_ncorner   <= '0;
            r_ovf       <= r_ovf_next | w_drop_next;
            r_ovf_next  <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
            if (w_accept) begin
                r_ncorner <= r_ncorner + 16'd1;
            end
            if (w_drop_cur) begin
                r_ovf <= 1'b1;
            end
            if (w_drop_next) begin
                r_ovf_next <= 1'b1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fast_corner_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fast_corner_packer
//  Description : Self-checking bench for fast_corner_packer. Directed frames
//                plus randomized pixel/backpressure traffic compared every
//                cycle against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fast_corner_packer;

    localparam int T_COL   = 640;
    localparam int T_ROW   = 480;
    localparam int T_DEPTH = 8;
    localparam int T_MAX   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] frame_cnt;
`ifdef FAST_PACK_SCORE_FILTER_EN
    logic [12:0] min_score = 13'd0;
`endif

    fast_corner_packer_if bus ();

    fast_corner_packer #(
        .COL_NUM     (T_COL),
        .ROW_NUM     (T_ROW),
        .FIFO_DEPTH  (T_DEPTH),
        .MAX_CORNERS (T_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
`ifdef FAST_PACK_SCORE_FILTER_EN
        .min_score (min_score),
`endif
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: FIFO contents as a queue, frame state as plain counters
    // ------------------------------------------------------------------------
    logic [31:0] mq[$];
    bit          md_cap_v;
    logic [31:0] md_cap_w;
    bit          md_fe1;
    bit          md_eofreq;
    bit          md_pend;
    int          md_ncorner;
    bit          md_ovf;
    bit          md_ovfn;
    int          md_fcnt;

    logic [32:0] dut_log[$];   // {last, data} of every word the DUT handed over

    function automatic logic [31:0] corner_word(int s, int y, int x);
        int sv;
        sv = (s > 2047) ? 2047 : s;
        return 32'((sv << 20) | (y << 10) | x);
    endfunction

    task automatic model_reset();
        mq.delete();
        md_cap_v = 0; md_cap_w = '0; md_fe1 = 0; md_eofreq = 0; md_pend = 0;
        md_ncorner = 0; md_ovf = 0; md_ovfn = 0; md_fcnt = 0;
    endtask

    task automatic model_step();
        int  fill;
        bit  pop, eof_wr, acc, drop_cur, drop_next;
        if (!rst) begin
            model_reset();
            return;
        end
        fill = mq.size();
        pop = (fill > 0) && bus.m_ready;
        eof_wr = (md_pend || md_eofreq) && (fill < T_DEPTH);
        acc = 0; drop_cur = 0; drop_next = 0;
        if (md_cap_v) begin
            if (md_pend || eof_wr)                          drop_next = 1;
            else if (fill <= T_DEPTH - 2 && md_ncorner < T_MAX) acc = 1;
            else                                            drop_cur = 1;
        end
        if (pop) void'(mq.pop_front());
        if (eof_wr) begin
            mq.push_back(32'h8000_0000 | (32'(md_ovf) << 30) | 32'(md_ncorner));
            md_ncorner = 0;
            md_ovf  = md_ovfn | drop_next;
            md_ovfn = 0;
            md_fcnt = (md_fcnt + 1) % 65536;
            md_pend = 0;
        end else begin
            if (md_eofreq) md_pend = 1;
            if (acc) begin
                mq.push_back(md_cap_w);
                md_ncorner++;
            end
            if (drop_cur)  md_ovf  = 1;
            if (drop_next) md_ovfn = 1;
        end
        md_eofreq = md_fe1;
        md_fe1 = bus.ce && bus.xy_coord_vld &&
                 (int'(bus.x_coord) == T_COL - 1) && (int'(bus.y_coord) == T_ROW - 1);
        md_cap_v = bus.ce && bus.xy_coord_vld && bus.iscorner;
        md_cap_w = corner_word(int'(bus.score), int'(bus.y_coord), int'(bus.x_coord));
    endtask

    task automatic check_outputs();
        logic [31:0] ed;
        bit ev;
        ev = (mq.size() > 0);
        ed = ev ? mq[0] : 32'd0;
        check_eq("m_valid",   64'(bus.m_valid), 64'(ev));
        check_eq("m_data",    64'(bus.m_data),  64'(ed));
        check_eq("m_last",    64'(bus.m_last),  64'(ev && ed[31]));
        check_eq("frame_cnt", 64'(frame_cnt),   64'(md_fcnt));
    endtask

    // One clock: log a handed-over word, advance model, check at negedge.
    task automatic cycle();
        if (bus.m_valid && bus.m_ready) dut_log.push_back({bus.m_last, bus.m_data});
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic pixel(bit c, bit v, bit corner, int x, int y, int s);
        bus.ce = c; bus.xy_coord_vld = v; bus.iscorner = corner;
        bus.x_coord = 10'(x); bus.y_coord = 10'(y); bus.score = 13'(s);
        cycle();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) pixel(1, 0, 0, 0, 0, 0);
    endtask

    task automatic frame_end(bit corner, int s);
        pixel(1, 1, corner, T_COL - 1, T_ROW - 1, s);
        idle(3);
    endtask

    function automatic logic [32:0] log_at(int i);
        if (i < dut_log.size()) return dut_log[i];
        return '1;
    endfunction

    initial begin
        bus.ce = 1; bus.xy_coord_vld = 0; bus.iscorner = 0;
        bus.x_coord = '0; bus.y_coord = '0; bus.score = '0; bus.m_ready = 0;
        model_reset();

        // ---------------- reset state ----------------
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        idle(2);

        // ---------------- two corners, last one on the frame-end pixel ------
        bus.m_ready = 1;
        dut_log.delete();
        pixel(1, 1, 1, 5, 2, 300);
        idle(3);
        frame_end(1, 5000);
        idle(6);
        check_eq("t1_count", 64'(dut_log.size()), 64'd3);
        check_eq("t1_w0",  64'(log_at(0)), 64'({1'b0, 32'h12C0_0805}));
        check_eq("t1_w1",  64'(log_at(1)), 64'({1'b0, 32'h7FF7_7E7F}));
        check_eq("t1_eof", 64'(log_at(2)), 64'({1'b1, 32'h8000_0002}));
        check_eq("t1_fcnt", 64'(frame_cnt), 64'd1);

        // ---------------- empty frame ----------------
        dut_log.delete();
        frame_end(0, 0);
        idle(4);
        check_eq("t2_count", 64'(dut_log.size()), 64'd1);
        check_eq("t2_eof",   64'(log_at(0)), 64'({1'b1, 32'h8000_0000}));

        // ---------------- corner cap with sink stalled ----------------
        dut_log.delete();
        bus.m_ready = 0;
        for (int i = 0; i < 9; i++) pixel(1, 1, 1, 10 + i, 7, 100 + i);
        frame_end(0, 0);
        bus.m_ready = 1;
        idle(12);
        check_eq("t3_count", 64'(dut_log.size()), 64'd6);
        check_eq("t3_eof",   64'(log_at(5)), 64'({1'b1, 32'hC000_0005}));

        // ---------------- fill limit, EOF reserve and EOF pending ----------
        dut_log.delete();
        bus.m_ready = 0;
        for (int i = 0; i < 4; i++) pixel(1, 1, 1, 20 + i, 1, 50);   // frame A
        frame_end(0, 0);
        for (int i = 0; i < 4; i++) pixel(1, 1, 1, 30 + i, 2, 60);   // frame B
        frame_end(0, 0);
        frame_end(0, 0);                                             // frame C
        check_eq("t3b_full", 64'(bus.m_valid), 64'd1);
        for (int i = 0; i < 2; i++) pixel(1, 1, 1, 40 + i, 3, 70);   // frame D (dropped)
        idle(2);
        bus.m_ready = 1;
        idle(14);
        frame_end(0, 0);                                             // end of D
        idle(4);
        check_eq("t3b_count", 64'(dut_log.size()), 64'd10);
        check_eq("t3b_eofA",  64'(log_at(4)), 64'({1'b1, 32'h8000_0004}));
        check_eq("t3b_eofB",  64'(log_at(7)), 64'({1'b1, 32'hC000_0002}));
        check_eq("t3b_eofC",  64'(log_at(8)), 64'({1'b1, 32'h8000_0000}));
        check_eq("t3b_eofD",  64'(log_at(9)), 64'({1'b1, 32'hC000_0000}));

        // ---------------- randomized traffic ----------------
        for (int f = 0; f < 36; f++) begin
            int mode, len;
            mode = f % 3;
            len = int'($urandom_range(10, 25));
            for (int i = 0; i < len + 4; i++) begin
                case (mode)
                    0:       bus.m_ready = ~bus.m_ready;
                    1:       bus.m_ready = 1'($urandom_range(0, 1));
                    default: bus.m_ready = ($urandom_range(0, 2) == 0);
                endcase
                if (i < len)
                    pixel(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, T_COL - 2)),
                          int'($urandom_range(0, T_ROW - 1)), int'($urandom_range(0, 8191)));
                else if (i == len)
                    pixel(1, 1, 1'($urandom_range(0, 1)), T_COL - 1, T_ROW - 1,
                          int'($urandom_range(0, 8191)));
                else
                    idle(1);
            end
        end
        bus.m_ready = 1;
        idle(20);

        // ---------------- reset mid-frame with two words buffered ----------
        bus.m_ready = 0;
        pixel(1, 1, 1, 3, 3, 10);
        pixel(1, 1, 1, 4, 3, 20);
        idle(3);
        check_eq("t6_buffered", 64'(bus.m_valid), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("t6_valid_rst", 64'(bus.m_valid), 64'd0);
        check_eq("t6_fcnt_rst",  64'(frame_cnt), 64'd0);
        model_reset();
        idle(2);
        rst = 1'b1;
        bus.m_ready = 1;
        dut_log.delete();
        idle(2);
        pixel(1, 1, 1, 100, 200, 3000);
        frame_end(0, 0);
        idle(3);
        check_eq("t6_count", 64'(dut_log.size()), 64'd2);
        check_eq("t6_w0",    64'(log_at(0)), 64'({1'b0, 32'h7FF3_2064}));
        check_eq("t6_eof",   64'(log_at(1)), 64'({1'b1, 32'h8000_0001}));
        check_eq("t6_fcnt",  64'(frame_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
